// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the RV32M multiply/divide unit:
//                funct3 operation codes, the funct7 value that selects the
//                M extension (shared with the ALU control decode) and the
//                unit's FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // funct7 value that, together with opcode 0110011, selects RV32M
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3 operation codes
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle RV32M multiply/divide unit. One operation is
//                accepted per valid/ready handshake; multiplies use unsigned
//                shift-add and divides use restoring shift-subtract, both on
//                operand magnitudes with a sign fix-up when entering DONE.
//                The result is held until the consumer takes it.
//  Ports       : clk        rising-edge clock
//                reset      synchronous active-high reset
//                flush      squash in-flight operation
//                in_valid   request valid
//                in_ready   unit idle, can accept
//                funct3     RV32M operation select
//                A, B       rs1 / rs2 operands
//                out_valid  Result valid
//                out_ready  consumer takes result
//                Result     selected result (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);

    state_t              r_state;
    state_t              w_state_nx;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_opb;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   r_acc;      // {hi, lo}: product, or {remainder, quotient}
    logic                r_neg;      // result needs two's-complement negation
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_result;

    // ------------------------------------------------------------------
    // Accept-side decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg_init;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = in_valid && (r_state == IDLE) && !flush;
    assign w_is_div   = funct3[2];
    assign w_a_signed = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
                        (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
    assign w_b_signed = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
                        (funct3 == FUNCT3_REM);
    assign w_a_neg    = w_a_signed && A[XLEN-1];
    assign w_b_neg    = w_b_signed && B[XLEN-1];
    assign w_a_mag    = w_a_neg ? ('0 - A) : A;
    assign w_b_mag    = w_b_neg ? ('0 - B) : B;

    // Remainder takes the dividend's sign; everything else is sign(A)^sign(B)
    assign w_neg_init = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (B == '0);
    assign w_overflow = w_is_div && !funct3[0] &&
                        (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    assign w_special  = w_div_zero || w_overflow;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? A : '1;
        end else if (w_overflow) begin
            w_special_res = funct3[1] ? '0 : A;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry, hi, lo} right by one.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nx;

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nx  = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: shift {rem, quot} left; the partial remainder needs one extra
    // bit because it can reach 2*divisor-1 before the trial subtract.
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_div_nx;

    assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_opb;
    assign w_div_nx = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // Final result with sign fix-up, taken from the last iteration's value
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_raw;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_final;
    logic              w_last;

    assign w_prod_fix = r_neg ? ('0 - w_mul_nx) : w_mul_nx;
    assign w_div_raw  = r_funct3[1] ? w_div_nx[2*XLEN-1:XLEN] : w_div_nx[XLEN-1:0];
    assign w_div_fix  = r_neg ? ('0 - w_div_raw) : w_div_raw;
    assign w_last     = (r_cnt == '0);

    always_comb begin
        w_final = w_prod_fix[2*XLEN-1:XLEN];
        if (r_funct3[2]) begin
            w_final = w_div_fix;
        end else if (r_funct3 == FUNCT3_MUL) begin
            w_final = w_prod_fix[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        if (flush) begin
            w_state_nx = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3 <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct3 <= funct3;
            r_neg    <= w_neg_init;
            r_cnt    <= CW'(XLEN-1);
            if (w_is_div) begin
                r_opb <= w_b_mag;
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
            end else begin
                r_opb <= w_a_mag;
                r_acc <= {{XLEN{1'b0}}, w_b_mag};
            end
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == CALC) && !flush) begin
            r_acc <= r_funct3[2] ? w_div_nx : w_mul_nx;
            if (w_last) begin
                r_result <= w_final;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign Result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (XLEN = 32). Expected
//                results come from a behavioural reference model and are
//                queued when an operation is driven, then popped and compared
//                when the unit raises out_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;

    int              checks   = 0;
    int              failures = 0;
    logic [31:0]     sb_q[$];
    logic [31:0]     last_res;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            FUNCT3_MUL:    begin p = ua * ub;           return p[31:0];  end
            FUNCT3_MULH:   begin p = sa * sb;           return p[63:32]; end
            FUNCT3_MULHSU: begin p = sa * $signed(ub);  return p[63:32]; end
            FUNCT3_MULHU:  begin p = ua * ub;           return p[63:32]; end
            FUNCT3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb;
                return p[31:0];
            end
            FUNCT3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            FUNCT3_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 0) ||
                         (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request from IDLE; returns just after the accept edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3   = f;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        sb_q.push_back(ref_result(f, a, b));
        step();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, checking latency, busy and result hold.
    task automatic wait_valid(input string tag, input int exp_lat);
        int          n;
        bit          moved;
        logic [31:0] exp;
        n     = 0;
        moved = 0;
        check_value({tag, "_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 100) begin
            if (Result !== last_res) moved = 1;
            step();
            n++;
        end
        check_value({tag, "_hold"}, 32'(moved), 32'd0);
        check_value({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check_value({tag, "_res"}, Result, exp);
            last_res = exp;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        start_op(f, a, b);
        wait_valid(tag, is_special(f, a, b) ? 0 : 32);
        step();
        check_value({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) hits++;
            step();
        end
        check_value({tag, "_no_valid"}, 32'(hits), 32'd0);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] held;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        funct3    = '0;
        A         = '0;
        B         = '0;
        repeat (3) step();
        reset    = 1'b0;
        last_res = 32'h0;
        check_value("rst_in_ready",  32'(in_ready),  32'd1);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_result",    Result,         32'h0);

        // Directed cases
        run_op("mul",     FUNCT3_MUL,    32'd10,          32'd15);
        run_op("mulh",    FUNCT3_MULH,   32'h8000_0000,   32'h8000_0000);
        run_op("mulhu",   FUNCT3_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF);
        run_op("mulhsu",  FUNCT3_MULHSU, 32'hFFFF_FFFF,   32'd2);
        run_op("div",     FUNCT3_DIV,    32'hFFFF_FFEC,   32'd3);
        run_op("rem",     FUNCT3_REM,    32'hFFFF_FFEC,   32'd3);
        run_op("divu",    FUNCT3_DIVU,   32'd20,          32'd3);
        run_op("remu",    FUNCT3_REMU,   32'd20,          32'd3);
        run_op("divu_z",  FUNCT3_DIVU,   32'd7,           32'd0);
        run_op("rem_z",   FUNCT3_REM,    32'd7,           32'd0);
        run_op("div_ovf", FUNCT3_DIV,    32'h8000_0000,   32'hFFFF_FFFF);
        run_op("rem_ovf", FUNCT3_REM,    32'h8000_0000,   32'hFFFF_FFFF);
        run_op("rem_neg", FUNCT3_REM,    32'd20,          32'hFFFF_FFF9);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            run_op("rand", rf, ra, rb);
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        start_op(FUNCT3_MUL, 32'd7, 32'd9);
        wait_valid("bp", 32);
        held = last_res;
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("bp_valid", 32'(out_valid), 32'd1);
            check_value("bp_res",   Result,         held);
            check_value("bp_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        step();
        check_value("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

        // Flush at CALC cycle 10
        start_op(FUNCT3_DIVU, 32'd1000, 32'd7);
        void'(sb_q.pop_back());
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_value("flush_idle", {30'd0, out_valid, in_ready}, 32'b01);
        check_value("flush_res",  Result, last_res);
        watch_quiet("flush", 40);
        run_op("post_flush", FUNCT3_MUL, 32'd3, 32'd4);

        // Flush in IDLE blocks acceptance
        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = FUNCT3_MUL;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_value("flush_idle_block", 32'(in_ready), 32'd1);

        // Reset at CALC cycle 20
        start_op(FUNCT3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        void'(sb_q.pop_back());
        repeat (20) step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        last_res = 32'h0;
        check_value("reset_idle", {30'd0, out_valid, in_ready}, 32'b01);
        check_value("reset_res",  Result, 32'h0);
        watch_quiet("reset", 40);
        run_op("post_reset", FUNCT3_MUL, 32'd3, 32'd4);

        check_value("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
